// File: rtl/mux3_rr_arbiter_pkg.sv
// mux3_arb_pkg: shared select encodings, FSM states and round-robin helper
package mux3_arb_pkg;
    localparam int NUM_REQ = 3;
    localparam logic [1:0] SEL_HOLD = 2'b00;
    localparam logic [1:0] SEL_A    = 2'b01;
    localparam logic [1:0] SEL_B    = 2'b10;
    localparam logic [1:0] SEL_C    = 2'b11;
    typedef enum logic {ST_IDLE, ST_GRANT} state_t;
    function automatic logic [1:0] nxt3(input logic [1:0] x);
        return (x >= 2'd2) ? 2'd0 : x + 2'd1;
    endfunction
endpackage

// File: rtl/mux3_rr_arbiter_pick.sv
// rr_pick3: first requester at or after ptr (wrapping C->A) not masked by excl
module rr_pick3
    import mux3_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [1:0]         ptr,
    input  logic [NUM_REQ-1:0] excl,
    output logic               found,
    output logic [1:0]         idx
);
    logic [NUM_REQ-1:0] c;
    logic [1:0] p0, p1, p2;
    always_comb begin
        c     = req & ~excl;
        p0    = (ptr == 2'd3) ? 2'd0 : ptr;
        p1    = nxt3(p0);
        p2    = nxt3(p1);
        found = |c;
        idx   = c[p0] ? p0 : c[p1] ? p1 : p2;
    end
endmodule

// File: rtl/mux3_rr_arbiter.sv
// mux3_rr_arbiter: round-robin owner of the 3-input registered mux with a
// per-grant hold limit that forces rotation under contention
module mux3_rr_arbiter
    import mux3_arb_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    output logic [1:0]         select,
    output logic               mux_valid,
    output logic [1:0]         owner
);
    localparam int CNT_W = $clog2(MAX_HOLD + 1);
    state_t             state, nx_state;
    logic [CNT_W-1:0]   cnt, nx_cnt;
    logic [1:0]         last, nx_owner, idx;
    logic [NUM_REQ-1:0] excl;
    logic               found, keep, at_max, nx_switch, nx_active;
    rr_pick3 u_pick (
        .req   (req),
        .ptr   (nxt3(last)),
        .excl  (excl),
        .found (found),
        .idx   (idx)
    );
    // The current owner is never its own successor; if nobody else waits it simply keeps the grant.
    always_comb begin
        excl      = (state == ST_GRANT) ? (3'b001 << owner) : 3'b000;
        keep      = (state == ST_GRANT) && req[owner];
        at_max    = (cnt == CNT_W'(MAX_HOLD));
        nx_switch = found && (!keep || at_max);
        nx_active = nx_switch || keep;
        nx_owner  = nx_switch ? idx : keep ? owner : 2'd0;
        nx_cnt    = nx_switch ? CNT_W'(1) : !keep ? '0 : at_max ? CNT_W'(1) : cnt + CNT_W'(1);
        nx_state  = nx_active ? ST_GRANT : ST_IDLE;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            owner     <= 2'd0;
            cnt       <= '0;
            last      <= 2'd2;
            grant     <= '0;
            select    <= SEL_HOLD;
            mux_valid <= 1'b0;
        end else begin
            state     <= nx_state;
            owner     <= nx_owner;
            cnt       <= nx_cnt;
            if (nx_switch)
                last <= idx;
            grant     <= nx_active ? (3'b001 << nx_owner) : 3'b000;
            select    <= nx_active ? nx_owner + 2'd1 : SEL_HOLD;
            mux_valid <= (select != SEL_HOLD);
        end
    end
endmodule

// File: tb/tb_mux3_rr_arbiter.sv
// tb_mux3_rr_arbiter: two arbiters (hold limits 8 and 3) against a behavioural model
module tb_mux3_rr_arbiter;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] req = 3'b000;
    logic [2:0] g0, g1;
    logic [1:0] s0, s1, o0, o1;
    logic       v0, v1;
    int tests = 0, fails = 0;
    int mh[2]     = '{8, 3};
    int m_own[2]  = '{-1, -1};
    int m_cnt[2]  = '{0, 0};
    int m_last[2] = '{2, 2};
    bit m_mv[2]   = '{0, 0};
    int waitc[2][3];

    always #5 clk = ~clk;

    mux3_rr_arbiter #(.MAX_HOLD(8)) dut0 (
        .clk(clk), .rst(rst), .req(req), .grant(g0), .select(s0), .mux_valid(v0), .owner(o0));
    mux3_rr_arbiter #(.MAX_HOLD(3)) dut1 (
        .clk(clk), .rst(rst), .req(req), .grant(g1), .select(s1), .mux_valid(v1), .owner(o1));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: walk the three requesters in rotation from last_served+1.
    task automatic model_step(input int k, input logic [2:0] r, input bit rs);
        int w;
        if (rs) begin
            m_own[k] = -1; m_cnt[k] = 0; m_last[k] = 2; m_mv[k] = 0;
            return;
        end
        m_mv[k] = (m_own[k] >= 0);
        w = -1;
        for (int j = 1; j <= 3; j++) begin
            int c;
            c = (m_last[k] + j) % 3;
            if (w < 0 && r[c] && c != m_own[k]) w = c;
        end
        if (m_own[k] < 0 || !r[m_own[k]] || m_cnt[k] == mh[k]) begin
            if (w >= 0) begin
                m_own[k] = w; m_cnt[k] = 1; m_last[k] = w;
            end else if (m_own[k] >= 0 && r[m_own[k]]) begin
                m_cnt[k] = 1;
            end else begin
                m_own[k] = -1; m_cnt[k] = 0;
            end
        end else begin
            m_cnt[k]++;
        end
    endtask

    task automatic compare(input int k, input logic [2:0] g, input logic [1:0] s,
                           input logic v, input logic [1:0] o);
        int eg, es, eo;
        eg = (m_own[k] < 0) ? 0 : (1 << m_own[k]);
        es = (m_own[k] < 0) ? 0 : m_own[k] + 1;
        eo = (m_own[k] < 0) ? 0 : m_own[k];
        chk($sformatf("d%0d grant", k), 32'(g), eg);
        chk($sformatf("d%0d select", k), 32'(s), es);
        chk($sformatf("d%0d mux_valid", k), 32'(v), 32'(m_mv[k]));
        chk($sformatf("d%0d owner", k), 32'(o), eo);
        for (int i = 0; i < 3; i++) begin
            waitc[k][i] = (req[i] && !g[i] && !rst) ? waitc[k][i] + 1 : 0;
            chk($sformatf("d%0d starve%0d", k, i), 32'(waitc[k][i] > 2 * mh[k] + 1), 0);
        end
    endtask

    task automatic cyc(input logic [2:0] r, input bit rs);
        req = r;
        rst = rs;
        @(posedge clk);
        model_step(0, r, rs);
        model_step(1, r, rs);
        @(negedge clk);
        compare(0, g0, s0, v0, o0);
        compare(1, g1, s1, v1, o1);
    endtask

    initial begin
        logic [2:0] r;
        cyc(3'b000, 1);
        cyc(3'b000, 1);
        for (int n = 0; n < 5; n++) cyc(3'b000, 0);
        chk("idle grant", 32'(g0), 0);
        chk("idle mux_valid", 32'(v0), 0);
        for (int n = 1; n <= 4; n++) begin
            cyc((n <= 3) ? 3'b010 : 3'b000, 0);
            if (n == 1) chk("single grant", 32'(g0), 32'b010);
            if (n == 2) chk("single valid", 32'(v0), 1);
            if (n == 4) chk("single release", 32'(g0), 0);
        end
        cyc(3'b000, 1);
        for (int n = 1; n <= 25; n++) begin
            cyc(3'b111, 0);
            if (n == 1)  chk("rr sel A", 32'(s0), 32'b01);
            if (n == 8)  chk("rr A held", 32'(s0), 32'b01);
            if (n == 9)  chk("rr sel B", 32'(s0), 32'b10);
            if (n == 17) chk("rr sel C", 32'(s0), 32'b11);
            if (n == 25) chk("rr sel A again", 32'(s0), 32'b01);
        end
        cyc(3'b000, 1);
        cyc(3'b101, 0);
        cyc(3'b101, 0);
        cyc(3'b100, 0);
        chk("handoff grant", 32'(g0), 32'b100);
        chk("handoff valid", 32'(v0), 1);
        for (int n = 0; n < 20; n++) cyc(3'b001, 0);
        chk("sole holder d1", 32'(g1), 32'b001);
        cyc(3'b000, 1);
        for (int n = 0; n < 3; n++) cyc(3'b010, 0);
        cyc(3'b111, 1);
        chk("mid reset grant", 32'(g0), 0);
        chk("mid reset select", 32'(s0), 0);
        cyc(3'b111, 0);
        chk("post reset A", 32'(g0), 32'b001);
        r = 3'b000;
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 3; i++)
                if ($urandom_range(5) == 0) r[i] = ~r[i];
            cyc(r, $urandom_range(199) == 0);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
